reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Owns the single write port of the 8x8-bit register file (WRITE/INADDRESS/IN).
- Shares that port between two write requesters: A (ALU writeback) and B (load/debug path). Each requester uses a valid/ready handshake.
- Also provides a sequenced clear that writes zero to every register, one per cycle, so software can wipe the file without pulsing the register-file reset.
- Sits between the datapath writeback sources and reg_file; its outputs drive reg_file directly.

Parameters:
- DATA_WIDTH, 8, width of register data
- ADDR_WIDTH, 3, width of register address
- NUM_REGS, 8, number of registers swept by a clear; must equal 2**ADDR_WIDTH

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- VALID_A  in  1  requester A has a write pending
- ADDR_A  in  ADDR_WIDTH  destination register for A
- DATA_A  in  DATA_WIDTH  write data for A
- READY_A  out  1  A's request is accepted this cycle (combinational)
- VALID_B  in  1  requester B has a write pending
- ADDR_B  in  ADDR_WIDTH  destination register for B
- DATA_B  in  DATA_WIDTH  write data for B
- READY_B  out  1  B's request is accepted this cycle (combinational)
- CLEAR  in  1  single-cycle pulse that starts the clear sweep
- BUSY  out  1  high while a clear sweep is in progress
- CLEAR_DONE  out  1  one-cycle pulse after the last clear write is issued
- WRITE  out  1  write enable to reg_file (registered)
- INADDRESS  out  ADDR_WIDTH  write address to reg_file (registered)
- IN  out  DATA_WIDTH  write data to reg_file (registered)

Behaviour:
- Reset (RESET=0, asynchronous):
  - WRITE=0, INADDRESS=0, IN=0.
  - BUSY=0, CLEAR_DONE=0.
  - State=IDLE, priority pointer=A, sweep counter=0.
- States: IDLE, CLEAR. No other states.
- IDLE, arbitration:
  - Only one VALID high: that requester wins.
  - Both VALID high: the requester named by the priority pointer wins.
  - READY is high only for the winner. READY is never high for a requester whose VALID is low.
- Handshake:
  - A transfer happens on a rising edge where VALID and READY are both high.
  - At that edge: WRITE<=1, INADDRESS<=winner address, IN<=winner data.
  - reg_file commits the write on the following edge. Total latency from handshake edge to register update is 1 cycle.
- No transfer at an edge: WRITE<=0. INADDRESS and IN hold their previous values.
- Throughput is one write per cycle, with no bubble between back-to-back grants.
- Priority pointer update:
  - After every grant, the pointer is set to the requester that did NOT win. This gives round-robin under contention and favours the idle side otherwise.
  - The pointer does not change when there is no grant.
- Requesters must hold VALID, ADDR and DATA stable until they see READY. Address/data changes while VALID is high and READY is low are illegal.
- CLEAR sampled high in IDLE:
  - Go to CLEAR. BUSY<=1 at that same edge. Counter=0.
  - No request is granted at that edge, even if VALID is high. CLEAR has priority over both requesters.
- CLEAR state:
  - READY_A=READY_B=0.
  - Each edge issues WRITE<=1, INADDRESS<=counter, IN<=0, then counter increments.
  - After the edge that issues address NUM_REGS-1: go to IDLE, BUSY<=0, CLEAR_DONE<=1 for exactly one cycle.
  - The sweep takes exactly NUM_REGS cycles.
- CLEAR asserted while already in CLEAR: ignored. No restart, no extension.
- Pending requests during a sweep stall, with VALID held high. Arbitration resumes in the first IDLE cycle after the sweep.
- RESET asserted mid-sweep or mid-transfer:
  - Immediately forces the reset values, including WRITE=0.
  - The sweep is abandoned; partially cleared registers are left as they are.
- Width rules:
  - Counter is wide enough to hold NUM_REGS-1.
  - INADDRESS takes the counter truncated to ADDR_WIDTH.
  - No arithmetic on data.

Decomposition:
- Shared package contents:
  - State encoding constants: IDLE, CLEAR.
  - Requester ID constants: REQ_A=0, REQ_B=1.
  - DATA_WIDTH and ADDR_WIDTH defaults, shared with reg_file.
- One sub-module is natural: rr_arbiter2. It is a 2-way round-robin grant unit holding the priority pointer, with inputs valid[1:0] and enable, and output grant[1:0].
- The top level holds the FSM, the sweep counter and the output registers.

Test Plan:
- Reset, then VALID_A=1, ADDR_A=3, DATA_A=8'h5A for one handshake -> READY_A=1 in that cycle; next cycle WRITE=1, INADDRESS=3, IN=8'h5A; reg_file reg3 reads 8'h5A afterwards.
- VALID_A and VALID_B both held high for 4 cycles (A: addr 1, data 8'h11; B: addr 2, data 8'h22) -> grants alternate A,B,A,B; WRITE stays high for 4 consecutive cycles.
- Only VALID_B high for 3 cycles -> B is granted every cycle; pointer ends at A; a subsequent tie grants A first.
- All registers loaded with 8'hFF, then CLEAR pulse -> BUSY high for 8 cycles; INADDRESS steps 0..7 with IN=0; CLEAR_DONE pulses once; all registers read 0.
- VALID_A asserted on the second cycle of a sweep -> READY_A stays 0 for the whole sweep; A is granted in the first cycle after BUSY falls; a second CLEAR pulse mid-sweep does not lengthen the sweep.
- RESET driven low on the 4th cycle of a sweep (not aligned to the clock) -> WRITE, BUSY and CLEAR_DONE go to 0 immediately; after release, state is IDLE and a tie grants A.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared constants for the register-file write arbiter
package reg_write_arbiter_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int NUM_REGS   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// rtl/reg_write_arbiter_if.sv - requester handshakes, clear control and reg_file write port
interface reg_write_arbiter_if #(
  parameter int DATA_WIDTH = reg_write_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_write_arbiter_pkg::ADDR_WIDTH
);
  logic                  VALID_A;
  logic [ADDR_WIDTH-1:0] ADDR_A;
  logic [DATA_WIDTH-1:0] DATA_A;
  logic                  READY_A;
  logic                  VALID_B;
  logic [ADDR_WIDTH-1:0] ADDR_B;
  logic [DATA_WIDTH-1:0] DATA_B;
  logic                  READY_B;
  logic                  CLEAR;
  logic                  BUSY;
  logic                  CLEAR_DONE;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic [DATA_WIDTH-1:0] IN;

  modport master (
    output VALID_A, ADDR_A, DATA_A, VALID_B, ADDR_B, DATA_B, CLEAR,
    input  READY_A, READY_B, BUSY, CLEAR_DONE, WRITE, INADDRESS, IN
  );

  modport slave (
    input  VALID_A, ADDR_A, DATA_A, VALID_B, ADDR_B, DATA_B, CLEAR,
    output READY_A, READY_B, BUSY, CLEAR_DONE, WRITE, INADDRESS, IN
  );

endinterface

// File: rtl/reg_write_arbiter_rr_arbiter2.sv
// rtl/reg_write_arbiter_rr_arbiter2.sv - two-way round-robin grant unit with priority pointer
module rr_arbiter2
  import reg_write_arbiter_pkg::*;
(
  input  logic       CLK,
  input  logic       RESET,
  input  logic [1:0] valid,
  input  logic       enable,
  output logic [1:0] grant
);

  // Requester that wins a tie; always points at the side that lost the last grant.
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) begin
        grant = (ptr == REQ_B) ? 2'b10 : 2'b01;
      end else begin
        grant = valid;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ptr <= REQ_A;
    end else if (grant[REQ_A]) begin
      ptr <= REQ_B;
    end else if (grant[REQ_B]) begin
      ptr <= REQ_A;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - shares the reg_file write port between two requesters and a clear sweep
module reg_write_arbiter #(
  parameter int DATA_WIDTH = reg_write_arbiter_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = reg_write_arbiter_pkg::ADDR_WIDTH,
  parameter int NUM_REGS   = reg_write_arbiter_pkg::NUM_REGS
) (
  input  logic               CLK,
  input  logic               RESET,
  reg_write_arbiter_if.slave bus
);
  import reg_write_arbiter_pkg::*;

  localparam int              CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_REGS - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       grant;
  logic             arb_en;

  // A CLEAR pulse in IDLE outranks both requesters on the same edge.
  assign arb_en = (state == IDLE) && !bus.CLEAR;

  rr_arbiter2 u_rr (
    .CLK    (CLK),
    .RESET  (RESET),
    .valid  ({bus.VALID_B, bus.VALID_A}),
    .enable (arb_en),
    .grant  (grant)
  );

  assign bus.READY_A = grant[REQ_A];
  assign bus.READY_B = grant[REQ_B];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      cnt            <= '0;
      bus.BUSY       <= 1'b0;
      bus.CLEAR_DONE <= 1'b0;
      bus.WRITE      <= 1'b0;
      bus.INADDRESS  <= '0;
      bus.IN         <= '0;
    end else begin
      bus.CLEAR_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.CLEAR) begin
            state     <= CLEAR;
            cnt       <= '0;
            bus.BUSY  <= 1'b1;
            bus.WRITE <= 1'b0;
          end else if (grant[REQ_A]) begin
            bus.WRITE     <= 1'b1;
            bus.INADDRESS <= bus.ADDR_A;
            bus.IN        <= bus.DATA_A;
          end else if (grant[REQ_B]) begin
            bus.WRITE     <= 1'b1;
            bus.INADDRESS <= bus.ADDR_B;
            bus.IN        <= bus.DATA_B;
          end else begin
            bus.WRITE <= 1'b0;
          end
        end
        CLEAR: begin
          bus.WRITE     <= 1'b1;
          bus.INADDRESS <= ADDR_WIDTH'(cnt);
          bus.IN        <= '0;
          if (cnt == LAST) begin
            state          <= IDLE;
            cnt            <= '0;
            bus.BUSY       <= 1'b0;
            bus.CLEAR_DONE <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
